// File: rtl/loong_pkg.sv
// loong_pkg: shared types and constants for the LOONG round datapath.
//   nibble_t     - one GF(2^4) state element
//   LOONG_POLY   - reduction polynomial x^4 + x + 1
//   MIXROW_FWD/INV - packed 4x4 MixRow matrix, element [r][c] at bits
//                  ((r*N+c)*W) +: W; the matrix is involutory, so the inverse
//                  equals the forward matrix
//   mix_state_e  - MixRow sequencer states
//   pack_idx()   - bit offset of element [r][c] in a packed N x N state
package loong_pkg;

    localparam int LOONG_N = 4;
    localparam int LOONG_W = 4;

    typedef logic [LOONG_W-1:0] nibble_t;

    localparam logic [LOONG_W:0] LOONG_POLY = 5'h13;

    // Rows {1,4,9,13},{4,1,13,9},{9,13,1,4},{13,9,4,1}; row 0 sits in the
    // least significant 16 bits, column 0 in the least significant nibble.
    localparam logic [LOONG_N*LOONG_N*LOONG_W-1:0] MIXROW_FWD = 64'h149D_41D9_9D14_D941;
    localparam logic [LOONG_N*LOONG_N*LOONG_W-1:0] MIXROW_INV = MIXROW_FWD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mix_state_e;

    function automatic int pack_idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^W) multiplier, shift-and-add with reduction.
//   a_i - multiplicand (W bits)
//   b_i - multiplier (W bits)
//   p_o - product a_i * b_i mod POLY (W bits)
module gf_mul
    import loong_pkg::*;
#(
    parameter int             W    = 4,
    parameter logic [W:0]     POLY = LOONG_POLY
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o
);

    always_comb begin
        logic [W:0]   sh;
        logic [W-1:0] acc;
        acc = '0;
        sh  = {1'b0, a_i};
        for (int i = 0; i < W; i++) begin
            if (b_i[i]) begin
                acc = acc ^ sh[W-1:0];
            end
            // Multiply by x, folding the overflow term back via POLY.
            sh = sh << 1;
            if (sh[W]) begin
                sh = sh ^ POLY;
            end
        end
        p_o = acc;
    end

endmodule

// File: rtl/mix_row_seq.sv
// mix_row_seq: row-serial MixRow stage. Multiplies an N x N state of GF(2^W)
// elements by a constant MDS matrix, one output row per clock:
//   out[j][k] = XOR_l gmul(in[j][l], M[l][k])
// Ports:
//   clock, rst       - clock; asynchronous active-low reset
//   abort            - synchronous cancel of the block in flight
//   in_valid/in_ready, in_inv, in_state   - input block and matrix select
//   out_valid/out_ready, out_state        - result block
//   busy             - high while a block is computing or awaiting pickup
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload until that edge; ready
// may be high or low independent of valid. in_ready is high only in IDLE,
// out_valid only in DONE, so one block is resident at a time.
module mix_row_seq
    import loong_pkg::*;
#(
    parameter int                 N       = 4,
    parameter int                 W       = 4,
    parameter logic [W:0]         POLY    = loong_pkg::LOONG_POLY,
    parameter logic [N*N*W-1:0]   MAT_FWD = loong_pkg::MIXROW_FWD,
    parameter logic [N*N*W-1:0]   MAT_INV = loong_pkg::MIXROW_INV
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [N*N*W-1:0]   in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*N*W-1:0]   out_state,
    output logic               busy
);

    localparam int               ROW_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);

    // Control state grouped so checkers can bind to one signal.
    typedef struct packed {
        mix_state_e       state;
        logic [ROW_W-1:0] row;
    } ctrl_t;

    ctrl_t              ctrl_q;
    logic [N*N*W-1:0]   state_q;
    logic               inv_q;
    logic [N*N*W-1:0]   out_state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [N*N*W-1:0]   mat_sel;
    logic [W-1:0]       row_in  [N];
    logic [W-1:0]       prod    [N][N];
    logic [W-1:0]       row_out [N];

    // The mode is latched with the block, so the matrix cannot change mid-block.
    assign mat_sel = inv_q ? MAT_INV : MAT_FWD;

    // Current input row j = ctrl_q.row.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            row_in[l] = '0;
        end
        for (int l = 0; l < N; l++) begin
            row_in[l] = state_q[pack_idx(int'(ctrl_q.row), l, N, W) +: W];
        end
    end

    // One multiplier per (l, k) term of the current row.
    for (genvar gl = 0; gl < N; gl++) begin : g_l
        for (genvar gk = 0; gk < N; gk++) begin : g_k
            gf_mul #(
                .W    (W),
                .POLY (POLY)
            ) u_mul (
                .a_i (row_in[gl]),
                .b_i (mat_sel[((gl * N) + gk) * W +: W]),
                .p_o (prod[gl][gk])
            );
        end
    end

    // Column-wise XOR reduction of the products.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            row_out[k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) begin
                row_out[k] = row_out[k] ^ prod[l][k];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ctrl_q.state <= ST_IDLE;
            ctrl_q.row   <= '0;
            state_q      <= '0;
            inv_q        <= 1'b0;
            out_state_q  <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else if (abort) begin
            // Cancel wins over any handshake in the same cycle.
            ctrl_q.state <= ST_IDLE;
            ctrl_q.row   <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (ctrl_q.state)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q      <= in_state;
                        inv_q        <= in_inv;
                        ctrl_q.row   <= '0;
                        ctrl_q.state <= ST_COMPUTE;
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    for (int k = 0; k < N; k++) begin
                        out_state_q[pack_idx(int'(ctrl_q.row), k, N, W) +: W] <= row_out[k];
                    end
                    if (ctrl_q.row == ROW_LAST) begin
                        ctrl_q.state <= ST_DONE;
                        ctrl_q.row   <= '0;
                        out_valid_q  <= 1'b1;
                    end else begin
                        ctrl_q.row <= ctrl_q.row + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result held until taken; the next block waits for IDLE.
                    if (out_ready) begin
                        ctrl_q.state <= ST_IDLE;
                        out_valid_q  <= 1'b0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    ctrl_q.state <= ST_IDLE;
                    ctrl_q.row   <= '0;
                    in_ready_q   <= 1'b1;
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mix_row_seq.sv
module tb_mix_row_seq;

  localparam int SW = 64;

  // Reference matrices written row by row as they appear in the LOONG tables.
  localparam int MF [4][4] = '{'{1, 4, 9, 13}, '{4, 1, 13, 9}, '{9, 13, 1, 4}, '{13, 9, 4, 1}};
  localparam int MI [4][4] = '{'{1, 4, 9, 13}, '{4, 1, 13, 9}, '{9, 13, 1, 4}, '{13, 9, 4, 1}};

  logic          clock;
  logic          rst;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic          in_inv;
  logic [SW-1:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic          busy;

  int total;
  int bad;
  logic [SW-1:0] exp_q[$];

  mix_row_seq dut (
    .clock     (clock),
    .rst       (rst),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Carry-less product followed by polynomial long division.
  function automatic logic [3:0] gmul_ref(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (int'(a) << i);
    for (int bi = 6; bi >= 4; bi--)
      if (p[bi]) p = p ^ (32'h13 << (bi - 4));
    return p[3:0];
  endfunction

  function automatic logic [SW-1:0] mix_ref(input logic [SW-1:0] st, input bit inv);
    logic [SW-1:0] r;
    logic [3:0] acc;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) begin
        acc = '0;
        for (int l = 0; l < 4; l++)
          acc = acc ^ gmul_ref(st[(j*4+l)*4 +: 4], 4'(inv ? MI[l][k] : MF[l][k]));
        r[(j*4+k)*4 +: 4] = acc;
      end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a block and returns at the negedge after the accepting edge.
  task automatic send_block(input logic [SW-1:0] st, input logic inv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_wait: got in_ready=%0b expected 1", in_ready);
    end else begin
      in_valid = 1'b1;
      in_state = st;
      in_inv   = inv;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_state = {$urandom, $urandom};
      in_inv   = 1'($urandom_range(0, 1));
    end
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    send_block({$urandom, $urandom}, 1'b0);
    @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_compute: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++;
    if (out_state !== '0) begin bad++; $display("FAIL rst_out_state: got %h expected 0", out_state); end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_unit_rows();
    logic [SW-1:0] pat [2];
    logic [SW-1:0] want [2];
    int lat;
    pat[0] = 64'h1;  want[0] = 64'h0000_0000_0000_D941;
    pat[1] = 64'h2;  want[1] = 64'h0000_0000_0000_9182;
    for (int p = 0; p < 2; p++) begin
      send_block(pat[p], 1'b0);
      wait_valid(lat);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL unit_latency: got %0d expected 4", lat); end
      total++;
      if (out_state !== want[p]) begin bad++; $display("FAIL unit_result: got %h expected %h", out_state, want[p]); end
      ack();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL unit_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [SW-1:0] x;
    logic [SW-1:0] got;
    logic [SW-1:0] exp_v;
    int lat;
    for (int it = 0; it < 1000; it++) begin
      x = {$urandom, $urandom};
      exp_q.push_back(mix_ref(x, 1'b0));
      exp_q.push_back(x);
      send_block(x, 1'b0);
      wait_valid(lat);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
      got = out_state;
      exp_v = exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL fwd_result: got %h expected %h", got, exp_v); end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      ack();
      send_block(got, 1'b1);
      wait_valid(lat);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL inv_latency: got %0d expected 4", lat); end
      exp_v = exp_q.pop_front();
      total++;
      if (out_state !== exp_v) begin bad++; $display("FAIL round_trip: got %h expected %h", out_state, exp_v); end
      ack();
    end
  endtask

  task automatic test_stall();
    logic [SW-1:0] x;
    logic [SW-1:0] exp_v;
    int lat;
    x = {$urandom, $urandom};
    exp_v = mix_ref(x, 1'b1);
    send_block(x, 1'b1);
    wait_valid(lat);
    total++;
    if (out_state !== exp_v) begin bad++; $display("FAIL stall_result: got %h expected %h", out_state, exp_v); end
    // A competing block offered while DONE must be ignored.
    in_valid = 1'b1;
    in_state = {$urandom, $urandom};
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_ctrl: got valid=%b ready=%b busy=%b expected 1 0 1", out_valid, in_ready, busy);
      end
      total++;
      if (out_state !== exp_v) begin bad++; $display("FAIL stall_hold: got %h expected %h", out_state, exp_v); end
    end
    in_valid = 1'b0;
    ack();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_abort();
    logic [SW-1:0] y;
    int lat;
    bit seen;
    send_block({$urandom, $urandom}, 1'b0);
    repeat (2) @(negedge clock);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_state = {$urandom, $urandom};
    @(negedge clock);
    abort    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_ctrl: got ready=%b valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
    y = {$urandom, $urandom};
    send_block(y, 1'b1);
    wait_valid(lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL post_abort_latency: got %0d expected 4", lat); end
    total++;
    if (out_state !== mix_ref(y, 1'b1)) begin
      bad++;
      $display("FAIL post_abort_result: got %h expected %h", out_state, mix_ref(y, 1'b1));
    end
    ack();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);

    test_reset();
    test_unit_rows();
    test_round_trip();
    test_stall();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
